// File: rtl/trans_pkg.sv
// rtl/trans_pkg.sv - shared phase width, phase type and default carrier increment
package trans_pkg;

  localparam int PHASE_W = 8;

  typedef logic [PHASE_W-1:0] phase_t;

  localparam phase_t HALF_PERIOD = 8'd128;

  // 40 kHz carrier from a 50 MHz clock with a 32-bit accumulator
  localparam int unsigned DEFAULT_PHASE_INC = 32'd3435974;

endpackage

// File: rtl/trans_channel.sv
// rtl/trans_channel.sv - one transducer output: active phase register, modulo compare, output flop
module trans_channel
  import trans_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   enable_i,
  input  logic   load_i,
  input  phase_t phase_i,
  input  phase_t cnt_i,
  output logic   trans_o
);

  phase_t active_q, active_d;
  phase_t diff;
  logic   trans_q, trans_d;

  // the 8-bit subtraction wraps, so the high half-period follows the phase around the circle
  always_comb begin
    active_d = load_i ? phase_i : active_q;
    diff     = cnt_i - active_q;
    trans_d  = enable_i & (diff < HALF_PERIOD);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= '0;
      trans_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      trans_q  <= trans_d;
    end
  end

  assign trans_o = trans_q;

endmodule

// File: rtl/trans_phase_gen.sv
// rtl/trans_phase_gen.sv - phase-shifted 40 kHz transducer drive with period-aligned phase updates
// TRANS_EXT_SYNC_EN: resynchronise the accumulator to the master board's sync_in rising edge
module trans_phase_gen
  import trans_pkg::*;
#(
  parameter int          NUM_CHANNELS = 4,
  parameter int          ACC_W        = 32,
  parameter int unsigned PHASE_INC    = DEFAULT_PHASE_INC
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  phase_t                  phases [0:NUM_CHANNELS-1],
  input  logic                    phases_valid,
  input  logic                    enable,
  input  logic                    sync_in,
  output logic                    sync_out,
  output logic [NUM_CHANNELS-1:0] trans
);

  localparam logic [ACC_W-1:0] INC = ACC_W'(PHASE_INC);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   acc_sum;
  logic             wrap;
  logic             commit;
  logic             sync_edge;
  phase_t           cnt;

  phase_t pend_q [0:NUM_CHANNELS-1];
  phase_t pend_d [0:NUM_CHANNELS-1];
  logic   pend_flag_q, pend_flag_d;
  logic   sync_out_q, sync_out_d;

  assign acc_sum = {1'b0, acc_q} + {1'b0, INC};
  assign wrap    = enable & acc_sum[ACC_W];
  assign commit  = wrap & pend_flag_q;
  assign cnt     = acc_q[ACC_W-1 -: PHASE_W];

`ifdef TRANS_EXT_SYNC_EN
  logic sync_meta_q, sync_ff_q, sync_prev_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_meta_q <= 1'b0;
      sync_ff_q   <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_meta_q <= sync_in;
      sync_ff_q   <= sync_meta_q;
      sync_prev_q <= sync_ff_q;
    end
  end

  assign sync_edge = sync_ff_q & ~sync_prev_q;
`else
  logic unused_sync_in;
  assign unused_sync_in = sync_in;
  assign sync_edge      = 1'b0;
`endif

  // a strobe coinciding with a commit lands in pending after the old value has been committed
  always_comb begin
    acc_d = '0;
    if (enable) begin
      acc_d = sync_edge ? '0 : acc_sum[ACC_W-1:0];
    end
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    if (commit) begin
      pend_flag_d = 1'b0;
    end
    if (phases_valid) begin
      pend_d      = phases;
      pend_flag_d = 1'b1;
    end
    sync_out_d = enable & ~cnt[PHASE_W-1];
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      acc_q       <= '0;
      pend_flag_q <= 1'b0;
      sync_out_q  <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        pend_q[i] <= '0;
      end
    end else begin
      acc_q       <= acc_d;
      pend_flag_q <= pend_flag_d;
      sync_out_q  <= sync_out_d;
      pend_q      <= pend_d;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    trans_channel u_ch (
      .clk_i    (sys_clk),
      .rst_i    (rst),
      .enable_i (enable),
      .load_i   (commit),
      .phase_i  (pend_q[g]),
      .cnt_i    (cnt),
      .trans_o  (trans[g])
    );
  end

  assign sync_out = sync_out_q;

endmodule
